// File: rtl/mdu_pkg.sv
// Shared encodings and states for the multi-cycle multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// MULT/MULTU/DIV/DIVU with HI/LO; WIDTH+2 cycles start-to-done (divide by zero: 1 cycle).
// No backpressure: the issuer stalls on busy, and start is ignored while busy.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state, state_nx;
  logic             load, load_dz;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             neg_q, neg_r, fix_ph, fix_c, dz_r;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             start_dz;

  // Signed ops run on magnitudes; signs are reapplied in FIX.
  assign a_mag    = (op[0] && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
  assign b_mag    = (op[0] && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
  assign start_dz = op[1] && (dataB == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_dz  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nx = ST_IDLE;
        if (start) begin
          if (start_dz) begin
            state_nx = ST_DONE;
            load_dz  = 1'b1;
          end else begin
            state_nx = ST_RUN;
            load     = 1'b1;
          end
        end
      end
      ST_RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = ST_FIX;
      ST_FIX:  if (fix_ph) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // One WIDTH+1-bit adder serves shift-add, trial subtraction and the
  // two-cycle negation (low half first, its carry feeds the high half).
  logic [WIDTH:0] add_a, add_b, sum, shifted;
  logic           add_ci, ge, neg_hi;

  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign ge      = shifted[WIDTH] | ~sum[WIDTH];
  assign neg_hi  = op_r[1] ? neg_r : neg_q;
  assign sum     = add_a + add_b + (WIDTH+1)'(add_ci);

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == ST_RUN) begin
      if (op_r[1]) begin
        add_a  = shifted;
        add_b  = ~{1'b0, opb};
        add_ci = 1'b1;
      end else begin
        add_a = {1'b0, acc_hi};
        add_b = acc_lo[0] ? {1'b0, opb} : '0;
      end
    end else if (state == ST_FIX) begin
      add_a  = fix_ph ? {1'b0, ~acc_hi} : {1'b0, ~acc_lo};
      add_ci = fix_ph ? (op_r[1] | fix_c) : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      fix_ph <= 1'b0;
      fix_c  <= 1'b0;
      dz_r   <= 1'b0;
    end else if (load) begin
      op_r   <= op;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= a_mag;
      opb    <= b_mag;
      neg_q  <= op[0] & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
      neg_r  <= op[0] & dataA[WIDTH-1];
      fix_ph <= 1'b0;
      dz_r   <= 1'b0;
    end else if (load_dz) begin
      hi_r <= dataA;
      lo_r <= '1;
      dz_r <= 1'b1;
    end else if (state == ST_RUN) begin
      cnt <= cnt + 1'b1;
      if (op_r[1]) begin
        acc_hi <= ge ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], ge};
      end else begin
        acc_hi <= sum[WIDTH:1];
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      end
    end else if (state == ST_FIX) begin
      fix_ph <= ~fix_ph;
      if (!fix_ph) begin
        fix_c <= sum[WIDTH];
        if (neg_q && (op_r[0] || op_r[1])) acc_lo <= sum[WIDTH-1:0];
      end else begin
        hi_r <= neg_hi ? sum[WIDTH-1:0] : acc_hi;
        lo_r <= acc_lo;
      end
    end
  end

  assign busy     = (state == ST_RUN) || (state == ST_FIX);
  assign done     = (state == ST_DONE);
  assign div_zero = done & dz_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks of mul_div_unit: results, latency, div-by-zero, start masking, reset abort.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dataA = '0, dataB = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int lat, bcnt, ndone;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge after the start edge; returns edges until done.
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!done && l < 60) begin
      if (busy) b++;
      @(negedge clk);
      l++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb);
    op = o; dataA = a; dataB = bb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb,
                       output int l, output int b);
    @(negedge clk);
    issue(o, a, bb);
    wait_done(l, b);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("multu_lat", lat, 34);
    chk("multu_busy_cycles", bcnt, 34);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_dz", div_zero, 0);
    @(negedge clk);
    chk("done_pulse_1cyc", done, 0);
    chk("hold_hi", hi, 32'hFFFF_FFFE);

    do_op(MDU_MULT, -32'sd3, 32'sd5, lat, bcnt);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    do_op(MDU_DIV, -32'sd7, 32'sd2, lat, bcnt);
    chk("div_lat", lat, 34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    do_op(MDU_DIVU, 32'd100, 32'd0, lat, bcnt);
    chk("dz_lat", lat, 0);
    chk("dz_busy_cycles", bcnt, 0);
    chk("dz_flag", div_zero, 1);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h0000_0064);

    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_dz", div_zero, 0);

    do_op(MDU_DIVU, 32'd1000, 32'd7, lat, bcnt);
    chk("divu_lo", lo, 32'd142);
    chk("divu_hi", hi, 32'd6);

    // start during RUN must be ignored
    @(negedge clk);
    issue(MDU_MULTU, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    issue(MDU_DIVU, 32'd50, 32'd3);
    wait_done(lat, bcnt);
    chk("ign_lat", lat + 5, 34);
    chk("ign_lo", lo, 32'd42);
    chk("ign_hi", hi, 32'd0);

    // back-to-back issue from the DONE cycle
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("b2b_lat", lat, 34);
    chk("b2b_lo", lo, 32'd14);
    chk("b2b_hi", hi, 32'd2);

    // reset in the middle of RUN
    @(negedge clk);
    issue(MDU_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);

    do_op(MDU_DIVU, 32'd9, 32'd4, lat, bcnt);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_lo", lo, 32'd2);
    chk("post_rst_hi", hi, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
